// File: rtl/pkg_sfrs_definition.sv
// Shared definitions for the timer event controller: control SFR layout,
// IRQ FSM states, interrupt source encoding and source-selection helpers.
package pkg_sfrs_definition;

  localparam int CTRL_PS_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_CLR = 2'd2
  } irq_state_t;

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_MATCH0 = 2'd1;
  localparam logic [1:0] SRC_MATCH1 = 2'd2;
  localparam logic [1:0] SRC_OVF    = 2'd3;

  // int_en occupies bits [2:0]; everything above ps_ovf is reserved
  typedef struct packed {
    logic [CTRL_PS_W-1:0] ps_ovf;
    logic [CTRL_PS_W-1:0] ps_match1;
    logic [CTRL_PS_W-1:0] ps_match0;
    logic [1:0]           trig_sel;
    logic [2:0]           int_en;
  } tmr_evt_ctrl_t;

  localparam int CTRL_W = $bits(tmr_evt_ctrl_t);

  function automatic logic [1:0] irq_prio(input logic [2:0] pend);
    if (pend[2])      return SRC_OVF;
    else if (pend[0]) return SRC_MATCH0;
    else if (pend[1]) return SRC_MATCH1;
    else              return SRC_NONE;
  endfunction

  function automatic logic src_bit(input logic [1:0] src, input logic [2:0] vec);
    case (src)
      SRC_MATCH0: return vec[0];
      SRC_MATCH1: return vec[1];
      SRC_OVF:    return vec[2];
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tmr_evt_postscaler.sv
// Rising-edge detector plus postscaler for one timer event source.
module tmr_evt_postscaler #(
  parameter int PS_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic            evt,
  input  logic [PS_W-1:0] ps,
  output logic            qual
);

  logic            evt_p0;
  logic [PS_W-1:0] cnt_p0;
  logic            edge_det;
  logic            reach;

  assign edge_det = evt & ~evt_p0;
  // Compare with >= so that lowering ps below the running count fires on the next edge
  assign reach    = (cnt_p0 >= ps);
  assign qual     = clk_en & edge_det & reach;

  // Stage p0: input sample and edge counter
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_p0 <= 1'b0;
      cnt_p0 <= '0;
    end else if (clk_en) begin
      evt_p0 <= evt;
      if (edge_det) begin
        cnt_p0 <= reach ? '0 : cnt_p0 + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tmr_evt_ctrl.sv
// Timer event controller: postscaled event flags, trigger pulse and a
// three-state interrupt request handshake.
module tmr_evt_ctrl
  import pkg_sfrs_definition::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PS_W       = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  sys_clk_en,
  input  logic                  match0_event,
  input  logic                  match1_event,
  input  logic                  ovf_event,
  input  logic [DATA_WIDTH-1:0] evt_ctrl,
  input  logic [2:0]            flag_clr,
  input  logic                  irq_ack,
  output logic [2:0]            flags,
  output logic                  irq,
  output logic [1:0]            irq_src,
  output logic                  trig_out
);

  tmr_evt_ctrl_t   ctrl;
  logic [2:0]      evt_in;
  logic [2:0]      qual;
  logic [PS_W-1:0] ps [3];
  logic [2:0]      pending;
  logic            trig_hit;
  logic            unused_rsvd;
  irq_state_t      state;

  assign ctrl        = evt_ctrl[CTRL_W-1:0];
  assign unused_rsvd = ^evt_ctrl[DATA_WIDTH-1:CTRL_W];

  assign evt_in = {ovf_event, match1_event, match0_event};
  assign ps[0]  = PS_W'(ctrl.ps_match0);
  assign ps[1]  = PS_W'(ctrl.ps_match1);
  assign ps[2]  = PS_W'(ctrl.ps_ovf);

  for (genvar i = 0; i < 3; i++) begin : g_ps
    tmr_evt_postscaler #(.PS_W(PS_W)) u_ps (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .clk_en (sys_clk_en),
      .evt    (evt_in[i]),
      .ps     (ps[i]),
      .qual   (qual[i])
    );
  end

  assign trig_hit = src_bit(ctrl.trig_sel, qual);
  assign pending  = flags & ctrl.int_en;

  // Stage p1: sticky flags and trigger pulse (set beats clear)
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      flags    <= '0;
      trig_out <= 1'b0;
    end else if (sys_clk_en) begin
      flags    <= (flags & ~flag_clr) | qual;
      trig_out <= trig_hit;
    end
  end

  // Stage p2: interrupt request FSM
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= ST_IDLE;
      irq     <= 1'b0;
      irq_src <= SRC_NONE;
    end else if (sys_clk_en) begin
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            state   <= ST_REQ;
            irq     <= 1'b1;
            irq_src <= irq_prio(pending);
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state <= ST_WAIT_CLR;
            irq   <= 1'b0;
          end
        end
        ST_WAIT_CLR: begin
          if (!src_bit(irq_src, flags)) begin
            state   <= ST_IDLE;
            irq_src <= SRC_NONE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          irq     <= 1'b0;
          irq_src <= SRC_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmr_evt_ctrl.sv
// Directed bench for tmr_evt_ctrl with an expected-result queue.
module tb_tmr_evt_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        sys_clk_en;
  logic        match0_event;
  logic        match1_event;
  logic        ovf_event;
  logic [31:0] evt_ctrl;
  logic [2:0]  flag_clr;
  logic        irq_ack;
  logic [2:0]  flags;
  logic        irq;
  logic [1:0]  irq_src;
  logic        trig_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [2:0] f;
    logic       i;
    logic [1:0] s;
    logic       t;
  } exp_t;

  exp_t sb[$];

  tmr_evt_ctrl #(.DATA_WIDTH(32), .PS_W(4)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .sys_clk_en   (sys_clk_en),
    .match0_event (match0_event),
    .match1_event (match1_event),
    .ovf_event    (ovf_event),
    .evt_ctrl     (evt_ctrl),
    .flag_clr     (flag_clr),
    .irq_ack      (irq_ack),
    .flags        (flags),
    .irq          (irq),
    .irq_src      (irq_src),
    .trig_out     (trig_out)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] mk(input logic [2:0] en, input logic [1:0] sel,
                                     input logic [3:0] p0, input logic [3:0] p1,
                                     input logic [3:0] pov);
    return {15'd0, pov, p1, p0, sel, en};
  endfunction

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input logic [2:0] f, input logic i,
                      input logic [1:0] s, input logic t);
    exp_t e;
    e.tag = tag; e.f = f; e.i = i; e.s = s; e.t = t;
    sb.push_back(e);
  endtask

  task automatic chk_pop();
    exp_t e;
    e = sb.pop_front();
    cmp({e.tag, ".flags"},    32'(flags),    32'(e.f));
    cmp({e.tag, ".irq"},      32'(irq),      32'(e.i));
    cmp({e.tag, ".irq_src"},  32'(irq_src),  32'(e.s));
    cmp({e.tag, ".trig_out"}, 32'(trig_out), 32'(e.t));
  endtask

  // Drive, push the expectation, advance one clock, then compare.
  task automatic step(input string tag, input logic [2:0] f, input logic i,
                      input logic [1:0] s, input logic t);
    push(tag, f, i, s, t);
    cyc();
    chk_pop();
  endtask

  initial begin
    sys_rst = 1'b1; sys_clk_en = 1'b1;
    match0_event = 1'b0; match1_event = 1'b0; ovf_event = 1'b0;
    evt_ctrl = '0; flag_clr = '0; irq_ack = 1'b0;
    cyc();
    step("reset", 3'b000, 1'b0, 2'd0, 1'b0);
    sys_rst = 1'b0;

    // match0 held five cycles, postscale 0, trig_sel match0, int_en match0
    evt_ctrl = mk(3'b001, 2'd1, 4'd0, 4'd0, 4'd0);
    match0_event = 1'b1;
    step("m0_edge", 3'b001, 1'b0, 2'd0, 1'b1);
    step("m0_irq",  3'b001, 1'b1, 2'd1, 1'b0);
    cyc(); cyc();
    step("m0_hold", 3'b001, 1'b1, 2'd1, 1'b0);
    match0_event = 1'b0; irq_ack = 1'b1;
    step("m0_ack",  3'b001, 1'b0, 2'd1, 1'b0);
    irq_ack = 1'b0; flag_clr = 3'b001;
    step("m0_clr",  3'b000, 1'b0, 2'd1, 1'b0);
    flag_clr = 3'b000;
    step("m0_idle", 3'b000, 1'b0, 2'd0, 1'b0);

    // ovf postscale 3: qualifies on pulses 4 and 8
    evt_ctrl = mk(3'b000, 2'd3, 4'd0, 4'd0, 4'd3);
    for (int k = 1; k <= 8; k++) begin
      ovf_event = 1'b1;
      step($sformatf("ovf_p%0d", k), (k % 4 == 0) ? 3'b100 : 3'b000, 1'b0, 2'd0, (k % 4 == 0));
      ovf_event = 1'b0; flag_clr = 3'b111;
      step($sformatf("ovf_lo%0d", k), 3'b000, 1'b0, 2'd0, 1'b0);
      flag_clr = 3'b000;
    end
    // counter left at 0: with postscale 1 the next pulse must not qualify
    evt_ctrl = mk(3'b000, 2'd3, 4'd0, 4'd0, 4'd1);
    ovf_event = 1'b1;
    step("ovf_cnt0", 3'b000, 1'b0, 2'd0, 1'b0);
    ovf_event = 1'b0;
    cyc();
    ovf_event = 1'b1;
    step("ovf_cnt1", 3'b100, 1'b0, 2'd0, 1'b1);
    ovf_event = 1'b0; flag_clr = 3'b111;
    step("ovf_tidy", 3'b000, 1'b0, 2'd0, 1'b0);
    flag_clr = 3'b000;

    // set wins over simultaneous clear
    evt_ctrl = mk(3'b000, 2'd1, 4'd0, 4'd0, 4'd0);
    match0_event = 1'b1; flag_clr = 3'b001;
    step("setclr", 3'b001, 1'b0, 2'd0, 1'b1);
    match0_event = 1'b0; flag_clr = 3'b001;
    step("setclr_clr", 3'b000, 1'b0, 2'd0, 1'b0);
    flag_clr = 3'b000;

    // match0 + ovf together; trig_sel match1 so no trigger
    evt_ctrl = mk(3'b111, 2'd2, 4'd0, 4'd0, 4'd0);
    match0_event = 1'b1; ovf_event = 1'b1;
    step("pri_flags", 3'b101, 1'b0, 2'd0, 1'b0);
    match0_event = 1'b0; ovf_event = 1'b0;
    step("pri_req",   3'b101, 1'b1, 2'd3, 1'b0);
    irq_ack = 1'b1;
    step("pri_ack",   3'b101, 1'b0, 2'd3, 1'b0);
    irq_ack = 1'b0; flag_clr = 3'b100;
    step("pri_clr",   3'b001, 1'b0, 2'd3, 1'b0);
    flag_clr = 3'b000;
    step("pri_idle",  3'b001, 1'b0, 2'd0, 1'b0);
    irq_ack = 1'b1;
    step("pri_m0req", 3'b001, 1'b1, 2'd1, 1'b0);
    irq_ack = 1'b0;
    evt_ctrl = mk(3'b000, 2'd2, 4'd0, 4'd0, 4'd0);
    step("pri_noen",  3'b001, 1'b1, 2'd1, 1'b0);
    irq_ack = 1'b1;
    step("pri_ack2",  3'b001, 1'b0, 2'd1, 1'b0);
    irq_ack = 1'b0; flag_clr = 3'b001;
    step("pri_clr2",  3'b000, 1'b0, 2'd1, 1'b0);
    flag_clr = 3'b000;
    step("pri_done",  3'b000, 1'b0, 2'd0, 1'b0);

    // match1 postscale 7, count to 5, then lower to 2
    evt_ctrl = mk(3'b000, 2'd2, 4'd0, 4'd7, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      match1_event = 1'b1;
      step($sformatf("m1_p%0d", k), 3'b000, 1'b0, 2'd0, 1'b0);
      match1_event = 1'b0;
      cyc();
    end
    evt_ctrl = mk(3'b000, 2'd2, 4'd0, 4'd2, 4'd0);
    match1_event = 1'b1;
    step("m1_lower", 3'b010, 1'b0, 2'd0, 1'b1);
    match1_event = 1'b0; flag_clr = 3'b010;
    step("m1_clr",   3'b000, 1'b0, 2'd0, 1'b0);
    flag_clr = 3'b000;

    // reset while in REQ with match0 held high
    evt_ctrl = mk(3'b001, 2'd1, 4'd0, 4'd0, 4'd0);
    match0_event = 1'b1;
    step("rst_edge", 3'b001, 1'b0, 2'd0, 1'b1);
    step("rst_req",  3'b001, 1'b1, 2'd1, 1'b0);
    sys_rst = 1'b1;
    step("rst_mid",  3'b000, 1'b0, 2'd0, 1'b0);
    sys_rst = 1'b0;
    step("rst_new",  3'b001, 1'b0, 2'd0, 1'b1);
    step("rst_irq",  3'b001, 1'b1, 2'd1, 1'b0);

    // clock enable holds state; reset overrides enable
    match0_event = 1'b0; sys_clk_en = 1'b0; irq_ack = 1'b1;
    step("ce_hold",  3'b001, 1'b1, 2'd1, 1'b0);
    sys_clk_en = 1'b1;
    step("ce_run",   3'b001, 1'b0, 2'd1, 1'b0);
    irq_ack = 1'b0; sys_clk_en = 1'b0; sys_rst = 1'b1;
    step("ce_rst",   3'b000, 1'b0, 2'd0, 1'b0);
    sys_rst = 1'b0; sys_clk_en = 1'b1;

    cmp("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tmr_evt_ctrl.md
TMR_EVT_CTRL -- requirements
Module: tmr_evt_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, SFR word width; PS_W, default 4, postscaler counter width.
REQ-002 sys_clk  in  1  single system clock; all state on its rising edge.
REQ-003 sys_rst  in  1  synchronous, active-high reset.
REQ-004 sys_clk_en  in  1  when 0, all state holds.
REQ-005 match0_event, match1_event, ovf_event  in  1 each  level event outputs of the timer.
REQ-006 evt_ctrl  in  DATA_WIDTH  control SFR (fields per REQ-031).
REQ-007 flag_clr  in  3  write-1-clear pulses {ovf, match1, match0}.
REQ-008 irq_ack  in  1  interrupt acknowledge from the interrupt controller.
REQ-009 flags  out  3  sticky event flags {ovf, match1, match0}.
REQ-010 irq  out  1  interrupt request level.
REQ-011 irq_src  out  2  latched source: 0 none, 1 match0, 2 match1, 3 ovf.
REQ-012 trig_out  out  1  one-cycle trigger pulse for downstream peripherals.

Function
REQ-013 Each event input SHALL be registered; a rising edge is detected as the current input being 1 while the registered sample is 0, so a level held N cycles yields one edge.
REQ-014 Each source SHALL have a PS_W-bit postscaler counter, incremented on each detected edge.
REQ-015 A qualified event SHALL occur on an edge when count >= postscale field; the counter then returns to 0. Postscale 0 SHALL qualify every edge; postscale P SHALL qualify every (P+1)th edge.
REQ-016 Lowering postscale below the current count SHALL qualify on the next edge; no wrap-around stall.
REQ-017 A qualified event SHALL set its flag, visible the cycle after the clock edge that sampled the input edge.
REQ-018 flag_clr bit SHALL clear its flag on the next clock edge; simultaneous set and clear: set wins.
REQ-019 trig_out SHALL pulse for exactly one cycle, coincident with the flag rising, for the qualified event of the source selected by trig_sel (0 none, 1 match0, 2 match1, 3 ovf); simultaneous qualified events of unselected sources SHALL NOT pulse.
REQ-020 The IRQ FSM SHALL have states IDLE, REQ, WAIT_CLR.
REQ-021 IDLE -> REQ when (flags & int_en) != 0; irq_src latched by priority ovf > match0 > match1.
REQ-022 REQ: irq = 1; on irq_ack -> WAIT_CLR with irq = 0 the following cycle.
REQ-023 WAIT_CLR: when the flag named by irq_src is 0 -> IDLE, irq_src = 0; other still-pending enabled flags re-enter REQ from IDLE one cycle later.
REQ-024 irq_ack in IDLE or WAIT_CLR SHALL be ignored.
REQ-025 Clearing int_en while in REQ SHALL NOT withdraw irq; the request completes via ack.
REQ-026 irq asserts one cycle after the enabled flag rises (two cycles after the sampled edge).

Reset
REQ-027 On sys_rst: flags, irq, irq_src, trig_out, postscaler counters, event samples all 0; FSM IDLE.
REQ-028 An event input already high at the first cycle after reset SHALL count as one rising edge.
REQ-029 sys_rst SHALL override sys_clk_en.
REQ-030 Reset mid-operation (e.g., in REQ) SHALL drop irq the cycle after sys_rst is sampled.

Structure
REQ-031 pkg_sfrs_definition SHALL hold a packed struct tmr_evt_ctrl_t: int_en[2:0] {ovf, match1, match0}, trig_sel[1:0], ps_match0, ps_match1, ps_ovf (PS_W bits each), remaining bits reserved zero.
REQ-032 The package SHALL hold the FSM state enum and the irq_src encoding constants.
REQ-033 One sub-module, tmr_evt_postscaler (edge detect + counter + qualify), SHALL be instantiated three times.

Verification
REQ-034 ps_match0 = 0, match0_event high for 5 cycles -> one flag set, one trig_out pulse (trig_sel = 1), irq after 1 more cycle (int_en = 001).
REQ-035 ps_ovf = 3, 8 separate ovf pulses -> qualified on pulses 4 and 8 only; counter 0 afterwards.
REQ-036 match0 and ovf qualify same cycle, int_en = 111 -> irq_src = 3; after ack and clearing ovf flag, irq_src = 1 follows.
REQ-037 flag_clr[0] asserted the same cycle match0 qualifies -> flags[0] = 1.
REQ-038 ps_match1 = 7 with count 5, rewrite to 2 -> next match1 edge qualifies.
REQ-039 sys_rst asserted in REQ with match0_event held high -> irq = 0, flags = 0 next cycle; after release, one new edge and flag set.
